// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and default width for the countdown timer.
`default_nettype none

package countdown_pkg;

  localparam int WIDTH_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    EXPIRE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with pause, abort and a one-cycle done pulse.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN restarts from the last loaded value on expiry.
`default_nettype none

module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_val,
  output logic             load_ready,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             load_acc;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign load_ready = ((state_q == IDLE) || (state_q == EXPIRE)) && !abort;
  assign load_acc   = load_valid && load_ready;
  assign count      = count_q;
  assign done       = done_q;
  assign busy       = (state_q == RUN) || (state_q == PAUSE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load_acc) begin
      count_d = load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
      // A zero start value expires immediately without passing through RUN.
      if (load_val == '0) begin
        state_d = EXPIRE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN, PAUSE: begin
          if (en) begin
            if (count_q[WIDTH-1:1] == '0) begin
              count_d = '0;
              state_d = EXPIRE;
              done_d  = 1'b1;
            end else begin
              count_d = count_q - WIDTH'(1);
              state_d = RUN;
            end
          end else begin
            state_d = PAUSE;
          end
        end
        EXPIRE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            count_d = reload_q;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 3, giving the counter width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port load_valid, input, 1, request to load a new start value.
REQ-005 SHALL have port load_val, input, WIDTH, the start value, sampled on handshake.
REQ-006 SHALL have port load_ready, output, 1, load acceptance; a load is accepted on an edge where load_valid & load_ready.
REQ-007 SHALL have port en, input, 1, count enable; decrement only when high.
REQ-008 SHALL have port abort, input, 1, synchronous cancel of the current countdown.
REQ-009 SHALL have port count, output, WIDTH, the current count, registered.
REQ-010 SHALL have port busy, output, 1, high in RUN or PAUSE.
REQ-011 SHALL have port done, output, 1, one-cycle expiry pulse, registered.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSE and EXPIRE.
REQ-013 SHALL drive load_ready = (state==IDLE or state==EXPIRE) & !abort, combinationally.
REQ-014 Accepted load (value V>0) SHALL set count=V and state=RUN at that edge; first decrement possible at the next edge.
REQ-015 Accepted load with V=0 SHALL set count=0 and go directly to EXPIRE (done pulse next cycle, no RUN).
REQ-016 RUN with en=1 SHALL decrement count by 1; RUN with en=0 SHALL go to PAUSE with count held.
REQ-017 PAUSE with en=1 SHALL decrement and return to RUN; PAUSE with en=0 SHALL hold.
REQ-018 Decrement from 1 to 0 SHALL move to EXPIRE; done SHALL be 1 exactly during the EXPIRE cycle, with count=0.
REQ-019 Count SHALL never wrap below 0 (no transition from 0 to 2^WIDTH-1).
REQ-020 EXPIRE SHALL last one cycle, then go to IDLE, unless a load is accepted in EXPIRE (back-to-back; REQ-014/015 apply).
REQ-021 abort=1 in any state SHALL force IDLE, count=0 and done=0 at the next edge, with no done pulse; abort SHALL override a simultaneous load_valid and en.
REQ-022 Load requests in RUN or PAUSE SHALL be refused (load_ready=0); load_valid may stay high until accepted.

Reset
REQ-023 rst low SHALL asynchronously force state=IDLE, count=0, done=0, busy=0 and reload register=0.
REQ-024 Reset asserted mid-countdown SHALL discard the countdown; after release the block SHALL be idle with load_ready=1.

Configuration
REQ-025 Macro COUNTDOWN_AUTO_RELOAD_EN: when defined, the block SHALL store the last accepted load value; EXPIRE with no accepted load SHALL reload count to that value and enter RUN (periodic done pulses).
REQ-026 With COUNTDOWN_AUTO_RELOAD_EN defined, a stored value of 0 SHALL go to IDLE instead of reloading; a load accepted in EXPIRE SHALL replace the stored value. Only abort or reset SHALL return the timer to IDLE otherwise.
REQ-027 Without the macro, no reload register SHALL exist and REQ-020 SHALL apply unchanged.

Structure
REQ-028 Package countdown_pkg SHALL hold the state enum (IDLE, RUN, PAUSE, EXPIRE) and the WIDTH default constant.
REQ-029 No sub-module is needed; the FSM and counter datapath SHALL live in countdown_timer.

Verification (WIDTH=3)
REQ-030 Load 5, en=1 held -> count 5,4,3,2,1,0 on consecutive cycles; done=1 only on the count=0 cycle; then IDLE, load_ready=1.
REQ-031 Load 4, en pattern 1,0,0,1,1,1 -> count 4,3,3,3,2,1,0; busy=1 throughout; done once.
REQ-032 Load 0 -> next cycle done=1 with count=0, busy never asserted.
REQ-033 Load 3, abort when count=2 while load_valid=1 -> count=0 and IDLE, no done, load not accepted that cycle.
REQ-034 Load 7, rst low for half a cycle at count=4 -> count=0, done=0 immediately; after release load 2 counts 2,1,0.
REQ-035 With COUNTDOWN_AUTO_RELOAD_EN defined, load 2, en=1 held -> count 2,1,0,2,1,0,... with done every third cycle; abort stops it in IDLE.
